// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner: tear-free frame latch, per-digit blanking gap, active-low outputs.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int CLK_HZ     = 50000000,
    parameter int SCAN_HZ    = 1000,
    parameter int NUM_DIGITS = 4,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_n,
    output logic                    frame
);

    localparam int DIV = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
    localparam int PW  = $clog2(DIV);
    localparam int IW  = $clog2(NUM_DIGITS);

    logic [PW-1:0]           r_pcnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_dig_n;
    logic                    r_frame;

    logic                    w_slot_end;
    logic                    w_boundary;
    logic                    w_blank;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_lzb;
    logic [NUM_DIGITS-1:0]   w_dig_n_next;

    assign w_slot_end = (r_pcnt == PW'(DIV - 1));
    assign w_boundary = w_slot_end && (r_idx == IW'(NUM_DIGITS - 1));
    assign w_blank    = (r_pcnt < PW'(BLANK_CYC));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign w_nib[gi] = r_active[4*gi +: 4];
        end
    endgenerate

`ifdef SEG7_LZB_EN
    // w_zero_from[k] is set when nibbles k..NUM_DIGITS-1 are all zero
    logic [NUM_DIGITS:0] w_zero_from;
    assign w_zero_from[NUM_DIGITS] = 1'b1;
    assign w_lzb[0]                = 1'b0;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
            assign w_zero_from[gi] = (w_nib[gi] == 4'h0) && w_zero_from[gi+1];
        end
        for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lzb
            assign w_lzb[gi] = w_zero_from[gi];
        end
    endgenerate
`else
    assign w_lzb = '0;
`endif

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
            assign w_dig_n_next[gi] = w_blank || w_lzb[gi] || (r_idx != IW'(gi));
        end
    endgenerate

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt   <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_active <= '0;
            r_seg    <= 7'h7F;
            r_dig_n  <= '1;
            r_frame  <= 1'b0;
        end else begin
            r_pcnt <= w_slot_end ? '0 : r_pcnt + 1'b1;
            if (w_slot_end) begin
                r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end
            if (load) begin
                r_shadow <= value;
            end
            // A load landing on the boundary bypasses the shadow so it is not lost for a frame
            if (w_boundary) begin
                r_active <= load ? value : r_shadow;
            end
            r_seg   <= seg7_decode(w_nib[r_idx]);
            r_dig_n <= w_dig_n_next;
            r_frame <= w_boundary;
        end
    end

    assign seg   = r_seg;
    assign dig_n = r_dig_n;
    assign frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus pushes expected digit slots and frame times, a monitor pops them.
module tb_seg7_scan_driver;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        load  = 1'b0;
    logic [15:0] value = 16'h0;
    logic [6:0]  seg;
    logic [3:0]  dig_n;
    logic        frame;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
    } slot_t;

    slot_t slot_q[$];
    int    frame_q[$];

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver #(
        .CLK_HZ    (1600),
        .SCAN_HZ   (100),
        .NUM_DIGITS(4),
        .BLANK_CYC (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .value(value),
        .load (load),
        .seg  (seg),
        .dig_n(dig_n),
        .frame(frame)
    );

    always #5 clk = ~clk;

    // Edges since reset release: edge 1 is the first edge with rst low
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc=%0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cyc=%0d)", name, act, cyc);
        end
    endtask

    // Expected lit slots for one frame showing v, first nd digits only
    task automatic push_frame(input logic [15:0] v, input int nd);
        slot_t s;
        for (int d = 0; d < nd; d++) begin
`ifdef SEG7_LZB_EN
            if (d >= 1 && (v >> (4*d)) == 16'h0) continue;
`endif
            s.dig = ~(4'b0001 << d);
            s.seg = glyph[v[4*d +: 4]];
            slot_q.push_back(s);
        end
    endtask

    task automatic at_cyc(input int n);
        while (cyc != n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Load sampled on edge t
    task automatic do_load(input int t, input logic [15:0] v);
        at_cyc(t - 1);
        value = v;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
    endtask

    initial begin : monitor
        logic [3:0] prev;
        int         run;
        slot_t      e;
        prev = 4'hF;
        run  = 0;
        forever begin
            @(negedge clk);
            if (!$isunknown(dig_n)) begin
                check("onehot", 32'($countones(~dig_n) <= 1), 32'd1);
                if (dig_n != 4'hF) begin
                    run++;
                    if (prev == 4'hF) begin
                        if (slot_q.size() == 0) begin
                            check("slot_extra", {21'd0, dig_n, seg}, 32'h0);
                        end else begin
                            e = slot_q.pop_front();
                            check("slot", {21'd0, dig_n, seg}, {21'd0, e.dig, e.seg});
                        end
                    end
                end else if (prev != 4'hF) begin
                    check("slot_len", run, 3);
                    run = 0;
                end
                if (frame === 1'b1) begin
                    if (frame_q.size() == 0) check("frame_extra", cyc, 0);
                    else                     check("frame_cyc", cyc, frame_q.pop_front());
                end
            end
            prev = dig_n;
        end
    end

    initial begin
        push_frame(16'h0000, 4);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_seg",   seg,   7'h7F);
            check("rst_dig_n", dig_n, 4'hF);
            check("rst_frame", frame, 1'b0);
        end
        rst = 1'b0;

        push_frame(16'h1234, 4);
        frame_q.push_back(16);
        do_load(1, 16'h1234);
        check("first_blank", dig_n, 4'hF);
        @(posedge clk);
        #1;
        check("first_digit", dig_n, 4'b1110);

        // Mid-frame load must not tear the frame showing 1234
        push_frame(16'hABCD, 4);
        frame_q.push_back(32);
        do_load(22, 16'hABCD);

        // Shadow gets 5555, then a boundary-coincident load overrides it
        do_load(40, 16'h5555);
        push_frame(16'h0008, 4);
        frame_q.push_back(48);
        do_load(48, 16'h0008);

        push_frame(16'h0070, 4);
        push_frame(16'h0070, 2);
        frame_q.push_back(64);
        frame_q.push_back(80);
        do_load(50, 16'h0070);

        // Reset during the digit 2 slot of the second 0070 frame
        at_cyc(88);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_seg",   seg,   7'h7F);
        check("mid_rst_dig_n", dig_n, 4'hF);
        check("mid_rst_frame", frame, 1'b0);
        rst = 1'b0;
        push_frame(16'h0000, 4);
        frame_q.push_back(16);

        at_cyc(17);
        @(negedge clk);
        #1;
        check("slot_q_left",  slot_q.size(),  0);
        check("frame_q_left", frame_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
